// File: rtl/alarm_timer_if.sv
// alarm_timer_if
//   Bundles the timer's control and parameter-block signals.
//   slave  : the timer itself (takes start/interval_req/value, drives the rest)
//   master : the surrounding alarm FSM plus the parameter block
//
//   start_timer  1  start/restart request
//   interval_req 2  interval to time (ARM/DRIVER/PASSENGER/ALARM_ON)
//   value        4  registered duration from the parameter block
//   interval     2  select driven to the parameter block
//   remaining    4  seconds left in the current count
//   busy         1  timer is selecting, loading or counting
//   expired      1  one-cycle completion pulse
interface alarm_timer_if;
    logic       start_timer;
    logic [1:0] interval_req;
    logic [3:0] value;
    logic [1:0] interval;
    logic [3:0] remaining;
    logic       busy;
    logic       expired;

    modport slave (
        input  start_timer, interval_req, value,
        output interval, remaining, busy, expired
    );

    modport master (
        output start_timer, interval_req, value,
        input  interval, remaining, busy, expired
    );
endinterface

// File: rtl/alarm_timer.sv
// alarm_timer
//   Countdown timer fed by the alarm's time-parameter block. A start request
//   selects an interval, waits out the block's one-cycle registered read,
//   captures the duration in seconds and counts it down using a prescaler of
//   CLOCKS_PER_SEC cycles per second. Completion emits a one-cycle expired
//   pulse. A start in any state restarts the sequence.
//
//   clock  1  rising-edge system clock
//   reset  1  synchronous, active-high
//   tmr       alarm_timer_if.slave (see interface for signal list)
//
//   All outputs are registers; nothing combinational reaches an output.
module alarm_timer #(
    parameter int CLOCKS_PER_SEC = 100_000_000
) (
    input  logic          clock,
    input  logic          reset,
    alarm_timer_if.slave  tmr
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LOAD,
        COUNT,
        EXPIRE
    } state_t;

    localparam logic [31:0] PRESC_MAX = 32'(CLOCKS_PER_SEC - 1);

    state_t      state_q,     state_d;
    logic [1:0]  interval_q,  interval_d;
    logic [3:0]  remaining_q, remaining_d;
    logic [31:0] presc_q,     presc_d;
    logic        busy_q,      busy_d;
    logic        expired_q,   expired_d;
    logic        tick;

    // One-second tick: last prescaler cycle while counting.
    always_comb tick = (state_q == COUNT) && (presc_q == PRESC_MAX);

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves one
        // unassigned; an unassigned path would infer a latch.
        state_d     = state_q;
        interval_d  = interval_q;
        remaining_d = remaining_q;
        presc_d     = '0;          // prescaler sits at 0 outside COUNT

        case (state_q)
            IDLE: begin
            end

            // Parameter block registers the new select during this cycle.
            SELECT: state_d = LOAD;

            LOAD: begin
                if (tmr.value == 4'd0) begin
                    remaining_d = '0;
                    state_d     = EXPIRE;
                end else begin
                    remaining_d = tmr.value;
                    state_d     = COUNT;
                end
            end

            COUNT: begin
                if (tick) begin
                    // Wrap to 0 (presc_d default) and consume one second.
                    if (remaining_q > 4'd1) begin
                        remaining_d = remaining_q - 4'd1;
                    end else begin
                        remaining_d = '0;
                        state_d     = EXPIRE;
                    end
                end else begin
                    presc_d = presc_q + 32'd1;
                end
            end

            EXPIRE: begin
                remaining_d = '0;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // A start from any state wins over everything above, including a
        // coincident tick: remaining is frozen until the next LOAD.
        if (tmr.start_timer) begin
            state_d     = SELECT;
            interval_d  = tmr.interval_req;
            remaining_d = remaining_q;
            presc_d     = '0;
        end
    end

    // Status flags are registered from the next state so they line up with
    // the state register instead of being decoded after it.
    always_comb begin
        busy_d    = (state_d == SELECT) || (state_d == LOAD) || (state_d == COUNT);
        expired_d = (state_d == EXPIRE);
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (reset) begin
            state_q     <= IDLE;
            interval_q  <= '0;
            remaining_q <= '0;
            presc_q     <= '0;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            interval_q  <= interval_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            busy_q      <= busy_d;
            expired_q   <= expired_d;
        end
    end

    assign tmr.interval  = interval_q;
    assign tmr.remaining = remaining_q;
    assign tmr.busy      = busy_q;
    assign tmr.expired   = expired_q;

endmodule

// File: tb/tb_alarm_timer.sv
// tb_alarm_timer
//   Self-checking bench for alarm_timer with CLOCKS_PER_SEC = 4. A small
//   parameter-block model supplies the registered `value`. The reference
//   model describes each run by its start edge, captured duration and
//   deadline edge, and derives remaining/busy/expired arithmetically.
module tb_alarm_timer;

    localparam int CPS = 4;

    logic clock;
    logic reset;

    alarm_timer_if bus ();

    alarm_timer #(.CLOCKS_PER_SEC(CPS)) dut (
        .clock (clock),
        .reset (reset),
        .tmr   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Parameter block: ARM 6, DRIVER 8, PASSENGER 15, ALARM_ON 10.
    logic [3:0] params [4];
    initial params = '{4'd6, 4'd8, 4'd15, 4'd10};

    always @(posedge clock) bus.value <= params[bus.interval];

    // ---------------- reference model ----------------
    longint     n        = 0;     // edge counter
    longint     e0       = 0;     // edge at which the current run started
    longint     exp_edge = -1;    // edge at which the current run expires
    int         m_v      = 0;     // captured duration
    bit         active   = 1'b0;
    logic [1:0] m_int    = '0;
    logic [3:0] m_rem    = '0;
    bit         m_busy   = 1'b0;
    bit         m_exp    = 1'b0;

    always @(posedge clock) begin
        n     = n + 1;
        m_exp = 1'b0;
        if (reset) begin
            m_int  = '0;
            m_rem  = '0;
            m_busy = 1'b0;
            active = 1'b0;
        end else if (bus.start_timer) begin
            m_int  = bus.interval_req;
            e0     = n;
            active = 1'b1;
            m_busy = 1'b1;
        end else if (active) begin
            if (n == e0 + 2) begin
                m_v      = int'(bus.value);
                exp_edge = n + longint'(m_v) * CPS;
            end
            if (n >= e0 + 2) begin
                if (n == exp_edge) begin
                    m_rem  = '0;
                    m_exp  = 1'b1;
                    m_busy = 1'b0;
                    active = 1'b0;
                end else begin
                    m_rem = 4'(longint'(m_v) - (n - (e0 + 2)) / CPS);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (n > 0) begin
            checks++;
            if (bus.interval !== m_int) begin
                errors++;
                $display("FAIL model_interval edge %0d: got %0d expected %0d", n, bus.interval, m_int);
            end
            checks++;
            if (bus.remaining !== m_rem) begin
                errors++;
                $display("FAIL model_remaining edge %0d: got %0d expected %0d", n, bus.remaining, m_rem);
            end
            checks++;
            if (bus.busy !== m_busy) begin
                errors++;
                $display("FAIL model_busy edge %0d: got %0b expected %0b", n, bus.busy, m_busy);
            end
            checks++;
            if (bus.expired !== m_exp) begin
                errors++;
                $display("FAIL model_expired edge %0d: got %0b expected %0b", n, bus.expired, m_exp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Returns at the negedge just after the start was sampled (after E0).
    task automatic pulse_start(input logic [1:0] req);
        bus.interval_req = req;
        bus.start_timer  = 1'b1;
        @(negedge clock);
        bus.start_timer  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy && !bus.expired) break;
            @(negedge clock);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.expired !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy %0b expired %0b after 200 cycles", bus.busy, bus.expired);
        end
        @(negedge clock);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.remaining !== 4'd0 || bus.busy !== 1'b0 || bus.expired !== 1'b0 || bus.interval !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: rem %0d busy %0b exp %0b int %0d, expected 0 0 0 0",
                     bus.remaining, bus.busy, bus.expired, bus.interval);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_arm_delay();
        pulse_start(2'd0);
        checks++;
        if (bus.busy !== 1'b1 || bus.interval !== 2'd0) begin
            errors++;
            $display("FAIL arm_start: busy %0b int %0d, expected 1 0", bus.busy, bus.interval);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (bus.remaining !== 4'd6) begin
            errors++;
            $display("FAIL arm_load: remaining %0d expected 6", bus.remaining);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (bus.remaining !== 4'd5) begin
            errors++;
            $display("FAIL arm_first_tick: remaining %0d expected 5", bus.remaining);
        end
        repeat (16) @(negedge clock);
        checks++;
        if (bus.remaining !== 4'd1 || bus.expired !== 1'b0) begin
            errors++;
            $display("FAIL arm_last_second: remaining %0d expired %0b, expected 1 0", bus.remaining, bus.expired);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (bus.expired !== 1'b1 || bus.busy !== 1'b0 || bus.remaining !== 4'd0) begin
            errors++;
            $display("FAIL arm_expire: exp %0b busy %0b rem %0d, expected 1 0 0", bus.expired, bus.busy, bus.remaining);
        end
        @(negedge clock);
        checks++;
        if (bus.expired !== 1'b0) begin
            errors++;
            $display("FAIL arm_pulse_width: expired %0b expected 0", bus.expired);
        end
        wait_idle();
    endtask

    // Full 15 s count; the block is reprogrammed mid-count and must be ignored.
    task automatic test_passenger();
        int early;
        early = 0;
        pulse_start(2'd2);
        repeat (2) @(negedge clock);
        checks++;
        if (bus.remaining !== 4'd15 || bus.interval !== 2'd2) begin
            errors++;
            $display("FAIL passenger_load: rem %0d int %0d, expected 15 2", bus.remaining, bus.interval);
        end
        for (int i = 1; i <= 60; i++) begin
            if (i == 5) params[2] = 4'd3;
            @(negedge clock);
            if (i < 60 && bus.expired) early++;
        end
        checks++;
        if (bus.expired !== 1'b1 || early != 0) begin
            errors++;
            $display("FAIL passenger_expire: expired %0b early pulses %0d, expected 1 0", bus.expired, early);
        end
        wait_idle();
        params[2] = 4'd15;
    endtask

    task automatic test_zero_value();
        params[0] = 4'd0;
        @(negedge clock);
        pulse_start(2'd0);
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b1 || bus.expired !== 1'b0) begin
            errors++;
            $display("FAIL zero_load_cycle: busy %0b exp %0b, expected 1 0", bus.busy, bus.expired);
        end
        @(negedge clock);
        checks++;
        if (bus.expired !== 1'b1 || bus.busy !== 1'b0 || bus.remaining !== 4'd0) begin
            errors++;
            $display("FAIL zero_expire: exp %0b busy %0b rem %0d, expected 1 0 0", bus.expired, bus.busy, bus.remaining);
        end
        wait_idle();
        params[0] = 4'd6;
    endtask

    // Restart coinciding with a tick: no decrement, then a fresh ALARM_ON count.
    task automatic test_restart_tick();
        int early;
        early = 0;
        pulse_start(2'd1);
        repeat (14) @(negedge clock);
        checks++;
        if (bus.remaining !== 4'd5) begin
            errors++;
            $display("FAIL restart_pre: remaining %0d expected 5", bus.remaining);
        end
        repeat (3) @(negedge clock);
        bus.interval_req = 2'd3;
        bus.start_timer  = 1'b1;
        @(negedge clock);
        bus.start_timer  = 1'b0;
        checks++;
        if (bus.remaining !== 4'd5 || bus.expired !== 1'b0 || bus.interval !== 2'd3 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_on_tick: rem %0d exp %0b int %0d busy %0b, expected 5 0 3 1",
                     bus.remaining, bus.expired, bus.interval, bus.busy);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (bus.remaining !== 4'd10) begin
            errors++;
            $display("FAIL restart_reload: remaining %0d expected 10", bus.remaining);
        end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i < 40 && bus.expired) early++;
        end
        checks++;
        if (bus.expired !== 1'b1 || early != 0) begin
            errors++;
            $display("FAIL restart_expire: expired %0b early pulses %0d, expected 1 0", bus.expired, early);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_count();
        int pulses;
        pulses = 0;
        pulse_start(2'd1);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (bus.remaining !== 4'd0 || bus.busy !== 1'b0 || bus.interval !== 2'd0 || bus.expired !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rem %0d busy %0b int %0d exp %0b, expected 0 0 0 0",
                     bus.remaining, bus.busy, bus.interval, bus.expired);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.expired) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_no_pulse: %0d expired pulses, expected 0", pulses);
        end
    endtask

    task automatic test_restart_in_expire();
        pulse_start(2'd0);
        repeat (26) @(negedge clock);
        checks++;
        if (bus.expired !== 1'b1) begin
            errors++;
            $display("FAIL expire_restart_pulse: expired %0b expected 1", bus.expired);
        end
        bus.interval_req = 2'd2;
        bus.start_timer  = 1'b1;
        @(negedge clock);
        bus.start_timer  = 1'b0;
        checks++;
        if (bus.expired !== 1'b0 || bus.busy !== 1'b1 || bus.interval !== 2'd2 || bus.remaining !== 4'd0) begin
            errors++;
            $display("FAIL expire_restart_select: exp %0b busy %0b int %0d rem %0d, expected 0 1 2 0",
                     bus.expired, bus.busy, bus.interval, bus.remaining);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (bus.remaining !== 4'd15) begin
            errors++;
            $display("FAIL expire_restart_load: remaining %0d expected 15", bus.remaining);
        end
        wait_idle();
    endtask

    // Random starts, back-to-back restarts, resets and reprogramming; the
    // per-cycle model comparison does the checking.
    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bus.start_timer  = ($urandom_range(0, 15) == 0);
            bus.interval_req = 2'($urandom_range(0, 3));
            reset            = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) params[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
            @(negedge clock);
        end
        bus.start_timer = 1'b0;
        reset           = 1'b0;
        params          = '{4'd6, 4'd8, 4'd15, 4'd10};
        wait_idle();
    endtask

    initial begin
        reset            = 1'b1;
        bus.start_timer  = 1'b0;
        bus.interval_req = 2'd0;
        test_reset();
        test_arm_delay();
        test_passenger();
        test_zero_value();
        test_restart_tick();
        test_reset_mid_count();
        test_restart_in_expire();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_timer.md
# alarm_timer

Countdown timer that consumes the time parameters stored by the alarm FSM's time-parameter storage block. On a start request it drives that block's `interval` select, waits out the block's one-cycle registered read, captures the 4-bit duration in seconds and counts it down with an internal seconds prescaler. When the count reaches zero it emits a single-cycle `expired` pulse back to the alarm FSM.

## Interface

- CLOCKS_PER_SEC, default 100_000_000, clock cycles per one-second tick; must be ≥ 2. Benches use 4.
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- start_timer  input  1  start/restart request, sampled every cycle
- interval_req  input  2  interval to time: 00 ARM_DELAY, 01 DRIVER_DELAY, 10 PASSENGER_DELAY, 11 ALARM_ON
- value  input  4  duration in seconds from the parameter block; registered there, valid one cycle after `interval` changes
- interval  output  2  select driven to the parameter block
- remaining  output  4  seconds left in current count
- busy  output  1  high in SELECT, LOAD and COUNT
- expired  output  1  one-cycle pulse when the count completes

## Operation

- States: IDLE, SELECT, LOAD, COUNT, EXPIRE.
- Reset: state IDLE, `interval`=00, `remaining`=0, prescaler=0, `busy`=0, `expired`=0.
- IDLE: on `start_timer`, latch `interval_req` into `interval` and go to SELECT.
- SELECT: hold `interval` for one cycle so the parameter block registers the new value. Go to LOAD.
- LOAD: sample `value`.
  - If `value`=0: go to EXPIRE.
  - Otherwise: `remaining`=`value`, prescaler=0, go to COUNT.
- COUNT: prescaler increments each cycle. When it reaches CLOCKS_PER_SEC-1, it wraps to 0 and a tick occurs:
  - On a tick with `remaining`>1: decrement `remaining`.
  - On a tick with `remaining`=1: `remaining`=0 and go to EXPIRE.
- EXPIRE: `expired`=1 for this cycle only. `remaining`=0. Next state is IDLE.
- Restart: `start_timer` in SELECT, LOAD, COUNT or EXPIRE relatches `interval_req` and goes to SELECT.
  - `remaining` holds its current value until the next LOAD.
  - The prescaler is cleared.
  - In EXPIRE, the `expired` pulse of that cycle still occurs.
- Start vs tick: `start_timer` in the same cycle as a tick wins. There is no decrement and no EXPIRE.
- Prescaler: counts only in COUNT and is held at 0 elsewhere.
- Captured value: it is not re-read during COUNT, so reprogramming the parameter block mid-count does not affect the running count.
- Arithmetic: `remaining` is a 4-bit unsigned value and never underflows below 0. The prescaler is 32 bits.
- Reset mid-operation: returns to IDLE immediately with the reset values above. No `expired` pulse.
- `interval` output: changes only on a start and holds its last value in IDLE.

## Timing

- Start sampled at edge E0. State is SELECT after E0, LOAD after E1, COUNT after E2 (the `value` capture edge).
- Count duration: `expired` is high during the cycle after edge E2 + `value`·CLOCKS_PER_SEC. It drops at the next edge.
- `value`=0: `expired` is high in the cycle after E2.
- Every start yields exactly one `expired` pulse unless it is restarted or reset first.
- `busy` rises after E0. It falls when state enters EXPIRE and is low during the `expired` cycle.
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.

## Test plan

- Default ARM_DELAY (6), CLOCKS_PER_SEC=4, pulse `start_timer` with `interval_req`=00 at E0 -> `interval`=00; `remaining` reads 6 after E2, 5 after E6, …, 1 after E22; `expired` is high only in the cycle after E26; `busy` is low from E26.
- `interval_req`=10 with PASSENGER_DELAY=15 -> `remaining` steps 15 down to 1; `expired` is high only in the cycle after E2+60.
- ARM_DELAY reprogrammed to 0, then start with `interval_req`=00 -> no COUNT state; `expired` is high in the cycle after E2.
- DRIVER_DELAY (8): at `remaining`=5, assert `start_timer` with `interval_req`=11 in a tick cycle -> no decrement and no `expired`; `remaining` reloads to 10 (ALARM_ON) two edges later and a full 10 s count follows.
- `reset` asserted mid-COUNT -> next cycle `remaining`=0, `busy`=0, `interval`=00; no `expired` pulse ever occurs for that run.
- `start_timer` asserted in the EXPIRE cycle -> `expired` is high for that one cycle, then SELECT/LOAD follow and a new count runs.
